// File: rtl/cart_bus_arbiter_if.sv
// Requester port bundle for cart_bus_arbiter.
// master = requester side, slave = arbiter side.
interface cart_port_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Two-port arbiter sequencing single accesses onto the cart bus.
// Define CART_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module cart_bus_arbiter #(
  parameter int READ_CYCLES  = 16,
  parameter int WRITE_CYCLES = 64
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  cart_port_if.slave  p0,
  cart_port_if.slave  p1,
  output logic        busy,
  output logic [15:0] cart_address,
  output logic [7:4]  cart_tran_bank0_out,
  input  logic [7:0]  cart_tran_bank1_in,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [7:0] RD_LOAD = 8'(READ_CYCLES - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_CYCLES - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic        we_l;
  logic        port_l;
  logic [1:0]  ack_q;
  logic [7:0]  rdata0_q;
  logic [7:0]  rdata1_q;
  logic        any_req;
  logic        grant1;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        rd_active;
  logic        wr_active;

  assign any_req = p0.req | p1.req;

`ifdef CART_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie, hand the bus to whichever port did not win last time.
  assign grant1 = p1.req & (~p0.req | ~last_grant);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= grant1;
    end
  end
`else
  assign grant1 = p1.req & ~p0.req;
`endif

  assign sel_we    = grant1 ? p1.we    : p0.we;
  assign sel_addr  = grant1 ? p1.addr  : p0.addr;
  assign sel_wdata = grant1 ? p1.wdata : p0.wdata;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= 8'd0;
      we_l                <= 1'b0;
      port_l              <= 1'b0;
      ack_q               <= 2'b00;
      rdata0_q            <= 8'd0;
      rdata1_q            <= 8'd0;
      cart_address        <= 16'd0;
      cart_tran_bank1_out <= 8'd0;
    end else begin
      ack_q <= 2'b00;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            port_l              <= grant1;
            we_l                <= sel_we;
            cart_address        <= sel_addr;
            cart_tran_bank1_out <= sel_we ? sel_wdata : 8'd0;
            state               <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= we_l ? WR_LOAD : RD_LOAD;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          // Ack is registered so rdata and ack appear together.
          if (port_l) begin
            ack_q[1] <= 1'b1;
            if (!we_l) rdata1_q <= cart_tran_bank1_in;
          end else begin
            ack_q[0] <= 1'b1;
            if (!we_l) rdata0_q <= cart_tran_bank1_in;
          end
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rd_active = (state == STROBE) & ~we_l;
  assign wr_active = (state == STROBE) &  we_l;

  assign busy = (state != IDLE);

  assign cart_tran_bank0_out = {1'b0, ~wr_active, ~rd_active, wr_active};

  assign cart_tran_bank1_dir = we_l &
    ((state == SETUP) | (state == STROBE) | (state == DONE));

  assign p0.ack   = ack_q[0];
  assign p1.ack   = ack_q[1];
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule

// File: doc/cart_bus_arbiter.md
CART_BUS_ARBITER -- requirements
Module: cart_bus_arbiter

Interface
REQ-001 Parameter READ_CYCLES, default 16, number of clk_sys cycles RD strobe is held (legal 1..255).
REQ-002 Parameter WRITE_CYCLES, default 64, number of clk_sys cycles WR strobe is held (legal 1..255).
REQ-003 clk_sys  in  1  system clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 p0_req, p1_req  in  1 each  access request per port, level, held until ack.
REQ-006 p0_we, p1_we  in  1 each  1 = write, 0 = read; valid while req.
REQ-007 p0_addr, p1_addr  in  16 each  cart bus address; valid while req.
REQ-008 p0_wdata, p1_wdata  in  8 each  write data; valid while req.
REQ-009 p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  out  8 each  read data; valid from ack until next ack of that port.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 cart_address  out  16  cart bus address.
REQ-013 cart_tran_bank0_out  out  4 [7:4]  control: bit7=0, bit6=~wr_active, bit5=~rd_active, bit4=wr_active.
REQ-014 cart_tran_bank1_in  in  8  cart data bus input.
REQ-015 cart_tran_bank1_out  out  8  cart data bus output.
REQ-016 cart_tran_bank1_dir  out  1  1 = drive data onto cart.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE, DONE, RELEASE.
REQ-018 IDLE: if any req, select winner, latch its we/addr/wdata and port index, go SETUP; else stay.
REQ-019 SETUP (1 cycle): cart_address = latched addr; dir = latched we; bank1_out = wdata on write; strobes inactive; load counter with READ_CYCLES-1 or WRITE_CYCLES-1; go STROBE.
REQ-020 STROBE: rd_active (read) or wr_active (write) high; counter decrements each cycle; when counter == 0 go DONE.
REQ-021 DONE (1 cycle): strobes low; on read capture cart_tran_bank1_in into granted port's rdata; pulse granted port's ack; go RELEASE.
REQ-022 RELEASE (1 cycle): dir low; cart_address held; go IDLE.
REQ-023 Latency req-to-ack SHALL be READ_CYCLES+3 cycles for reads, WRITE_CYCLES+3 for writes, from IDLE sample of req.
REQ-024 Requester SHALL drop req the cycle after ack; req in RELEASE is ignored, so a held req restarts only from IDLE.
REQ-025 Latched command SHALL not change while busy even if requester inputs change.
REQ-026 Both req asserted in IDLE: arbitration per REQ-031/032; loser keeps req and is served next.
REQ-027 Only one ack SHALL be asserted per transaction; ports' rdata independent.
REQ-028 cart_tran_bank1_dir SHALL never be high while rd_active is high.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, busy 0, acks 0, rdata 0, cart_address 0, bank1_out 0, dir 0, rd_active 0, wr_active 0 (bank0_out = 4'b0110), last-grant = port 1.
REQ-030 Reset mid-transaction SHALL abort it with no ack; after release first IDLE cycle samples req normally.

Configuration
REQ-031 Macro CART_ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant port not granted last; last-grant updated at each grant.
REQ-032 Macro undefined: fixed priority, port 0 always wins simultaneous requests; last-grant logic absent.

Verification
REQ-033 p0 read addr 0xA123, bank1_in=0x5A -> address 0xA123 in SETUP, bit5 low 16 cycles, p0_ack at cycle 19, p0_rdata=0x5A.
REQ-034 p1 write addr 0x4000 data 0x10 -> dir high SETUP..DONE, bank1_out=0x10, bit4 high 64 cycles, p1_ack at cycle 67, p1_rdata unchanged.
REQ-035 p0 and p1 both req continuously from IDLE -> RR build: grants p0,p1,p0,p1; fixed build: p0 served first, p1 only after p0 drops req.
REQ-036 reset_n low during STROBE of write -> all outputs to reset values same cycle, no ack; later request completes normally.
REQ-037 p0 changes addr/wdata during STROBE -> cart_address/bank1_out keep latched values until RELEASE.
